// File: rtl/fetch.sv
// Instruction fetch front end: imem req/ack into a prefetch FIFO, issues one or two words to decode.
// Optional FETCH_PERF_EN adds the bubble_cnt output (issue-bubble counter).
module fetch #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] EXT_MASK = 16'h0000,
   parameter logic [15:0] EXT_OP   = 16'hFFFF
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        stall,
   output logic [15:0] ins,
   output logic        ins_en,
   output logic [15:0] ext,
   output logic [15:0] ins_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] bubble_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DROP
   } state_t;

   state_t        state, state_n;
   logic [15:0]   fetch_pc, fpc_n, addr_n;
   logic [15:0]   word_q [DEPTH];
   logic [15:0]   addr_q [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
   logic [CW-1:0] count, count_n;
   logic [15:0]   head_w, head_a, next_w;
   logic          need_ext, issue1, issue2, issue, push, space;
   logic [1:0]    pop_n;

   assign imem_req = (state != S_IDLE);

   assign rd_nxt   = rd_ptr + 1'b1;
   assign head_w   = word_q[rd_ptr];
   assign head_a   = addr_q[rd_ptr];
   assign next_w   = word_q[rd_nxt];
   assign need_ext = ((head_w & EXT_MASK) == EXT_OP);

   assign issue2 = !redirect && !stall && need_ext
                 && (count >= CW'(2));
   assign issue1 = !redirect && !stall && !need_ext
                 && (count != '0);
   assign issue  = issue1 | issue2;
   assign push   = (state == S_REQ) && imem_ack && !redirect;

   always_comb begin
      pop_n = 2'd0;
      unique case (1'b1)
         issue2:  pop_n = 2'd2;
         issue1:  pop_n = 2'd1;
         default: pop_n = 2'd0;
      endcase
   end

   // net count after this cycle's push/pop; a flush wins
   assign count_n = redirect ? '0
                  : count + CW'(push) - CW'(pop_n);
   assign space   = (count_n < CW'(DEPTH));

   always_comb begin
      state_n = state;
      fpc_n   = fetch_pc;
      addr_n  = imem_addr;
      unique case (state)
         S_IDLE: begin
            if (redirect) begin
               fpc_n   = redirect_pc;
               addr_n  = redirect_pc;
               state_n = S_REQ;
            end else if (space) begin
               addr_n  = fetch_pc;
               state_n = S_REQ;
            end
         end
         S_REQ: begin
            if (redirect) begin
               fpc_n   = redirect_pc;
               state_n = imem_ack ? S_IDLE : S_DROP;
            end else if (imem_ack) begin
               fpc_n = fetch_pc + 16'd1;
               if (space) addr_n = fetch_pc + 16'd1;
               else state_n = S_IDLE;
            end
         end
         S_DROP: begin
            if (redirect) fpc_n = redirect_pc;
            if (imem_ack) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk) begin
      if (push) begin
         word_q[wr_ptr] <= imem_data;
         addr_q[wr_ptr] <= imem_addr;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         state     <= S_IDLE;
         fetch_pc  <= RESET_PC;
         imem_addr <= RESET_PC;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         ins       <= '0;
         ext       <= '0;
         ins_pc    <= RESET_PC;
         ins_en    <= 1'b0;
      end else begin
         state     <= state_n;
         fetch_pc  <= fpc_n;
         imem_addr <= addr_n;
         count     <= count_n;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr + PW'(pop_n);
         end
         ins_en <= issue;
         if (issue) begin
            ins    <= head_w;
            ext    <= issue2 ? next_w : 16'h0000;
            ins_pc <= head_a;
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         bubble_cnt <= '0;
      end else if (!stall && !redirect && !issue
                   && bubble_cnt != 16'hFFFF) begin
         bubble_cnt <= bubble_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: queue-based reference model plus directed literal checks.
// Random phase drives stall, redirect, reset and memory latency.
module tb_fetch;

   localparam int          DEPTH = 4;
   localparam logic [15:0] RPC   = 16'h0000;
   localparam logic [15:0] MASK  = 16'hF000;
   localparam logic [15:0] OP    = 16'hA000;
   localparam logic [15:0] DEAD  = 16'hDEAD;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst = 1'b1;
   logic        imem_req, imem_ack = 1'b0;
   logic [15:0] imem_addr, imem_data = '0;
   logic        redirect = 1'b0, stall = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic [15:0] ins, ext, ins_pc;
   logic        ins_en;
`ifdef FETCH_PERF_EN
   logic [15:0] bubble_cnt;
   logic [15:0] m_bub;
`endif

   fetch #(
      .DEPTH(DEPTH), .RESET_PC(RPC),
      .EXT_MASK(MASK), .EXT_OP(OP)
   ) dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .stall(stall), .ins(ins), .ins_en(ins_en),
      .ext(ext), .ins_pc(ins_pc)
`ifdef FETCH_PERF_EN
      , .bubble_cnt(bubble_cnt)
`endif
   );

   always #5 cpu_clk = ~cpu_clk;

   int vectors = 0, miscompares = 0;

   // reference model: words fetched but not yet issued, in order
   logic [31:0] q[$];
   logic [15:0] mpc;
   logic        drop_pend = 1'b0;
   logic        m_en;
   logic [15:0] m_ins, m_ext, m_pc;

   int lat_max = 0, wait_cnt = 0;
   bit starve = 0, ext_tbl = 0, rnd_data = 0;
   logic [15:0] ack_log[$];
   logic [47:0] iss_log[$];

   function automatic bit needs_ext(logic [15:0] w);
      return (w & MASK) == OP;
   endfunction

   function automatic logic [15:0] mem_word(logic [15:0] a);
      logic [15:0] w;
      if (rnd_data) begin
         w = 16'($urandom);
         if ($urandom_range(0, 3) == 0) w[15:12] = 4'hA;
         if (w == DEAD) w = w ^ 16'h0001;
      end else if (ext_tbl && a == 16'd0) w = 16'hA123;
      else if (ext_tbl && a == 16'd1) w = 16'h5555;
      else if (ext_tbl && a == 16'd2) w = 16'h0001;
      else w = a + 16'h1000;
      return w;
   endfunction

   task automatic chk(string nm, logic [47:0] act,
                      logic [47:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cycle();
      bit ack;
      ack = 0;
      if (!cpu_rst && imem_req === 1'b1 && !starve) begin
         if (wait_cnt == 0) begin
            ack = 1;
            wait_cnt = $urandom_range(0, lat_max);
         end else begin
            wait_cnt--;
         end
      end
      imem_ack  = ack;
      imem_data = !ack ? 16'($urandom)
                : (drop_pend || redirect) ? DEAD
                : mem_word(imem_addr);
      if (cpu_rst) begin
         q.delete();
         mpc = RPC; drop_pend = 0; wait_cnt = 0;
         m_en = 0; m_ins = '0; m_ext = '0; m_pc = RPC;
      end else if (redirect) begin
         q.delete();
         m_en = 0;
         mpc = redirect_pc;
         drop_pend = imem_req && !ack;
      end else begin
         m_en = 0;
         if (!stall && q.size() > 0) begin
            if (!needs_ext(q[0][31:16])) begin
               m_en = 1; m_ins = q[0][31:16];
               m_ext = '0; m_pc = q[0][15:0];
               void'(q.pop_front());
            end else if (q.size() >= 2) begin
               m_en = 1; m_ins = q[0][31:16];
               m_ext = q[1][31:16]; m_pc = q[0][15:0];
               void'(q.pop_front());
               void'(q.pop_front());
            end
         end
         if (ack) begin
            if (drop_pend) begin
               drop_pend = 0;
            end else begin
               chk("ack_addr", imem_addr, mpc);
               ack_log.push_back(imem_addr);
               q.push_back({imem_data, mpc});
               mpc = mpc + 16'd1;
            end
         end
      end
`ifdef FETCH_PERF_EN
      if (cpu_rst) m_bub = '0;
      else if (!stall && !redirect && !m_en
               && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
`endif
      @(posedge cpu_clk);
      #1;
      chk("ins_en", ins_en, m_en);
      chk("ins", ins, m_ins);
      chk("ext", ext, m_ext);
      chk("ins_pc", ins_pc, m_pc);
      chk("occupancy",
          (q.size() + int'(imem_req && !drop_pend)) <= DEPTH, 1);
      if (ins_en) begin
         iss_log.push_back({ins, ext, ins_pc});
         if (ins == DEAD) chk("dead_issued", ins, 16'h0000);
      end
`ifdef FETCH_PERF_EN
      chk("bubble_cnt", bubble_cnt, m_bub);
`endif
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      cpu_rst = 1; redirect = 0; stall = 0;
      run(2);
      cpu_rst = 0;
      ack_log.delete();
      iss_log.delete();
   endtask

   initial begin
      int k;
      // plain stream, immediate acks
      starve = 0; lat_max = 0;
      do_reset();
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_ins_en", ins_en, 1'b0);
      chk("rst_ins", ins, 16'h0000);
      chk("rst_pc", ins_pc, RPC);
      run(30);
      chk("t1_nacks", ack_log.size() >= 3, 1);
      chk("t1_addr0", ack_log[0], 16'h0000);
      chk("t1_addr1", ack_log[1], 16'h0001);
      chk("t1_addr2", ack_log[2], 16'h0002);
      chk("t1_iss0", iss_log[0], 48'h1000_0000_0000);
      chk("t1_iss1", iss_log[1], 48'h1001_0000_0001);

      // stalled fill, then drain in order
      do_reset();
      stall = 1;
      run(20);
      chk("t2_fill", ack_log.size(), DEPTH);
      chk("t2_req_off", imem_req, 1'b0);
      stall = 0;
      run(12);
      chk("t2_niss", iss_log.size() >= 4, 1);
      for (int i = 0; i < 4; i++)
         chk("t2_order", iss_log[i][15:0], 16'(i));

      // extension pairing
      ext_tbl = 1;
      do_reset();
      run(20);
      chk("t3_p1", iss_log[0], 48'hA123_5555_0000);
      chk("t3_p2", iss_log[1], 48'h0001_0000_0002);
      ext_tbl = 0;

      // redirect while a request waits, drop ack 3 cycles later
      starve = 1;
      do_reset();
      k = 0;
      while (imem_req !== 1'b1 && k < 10) begin
         cycle(); k++;
      end
      chk("t4_req_up", imem_req, 1'b1);
      redirect = 1; redirect_pc = 16'h0040;
      cycle();
      redirect = 0;
      run(2);
      starve = 0; wait_cnt = 0;
      run(20);
      chk("t4_addr", ack_log[0], 16'h0040);
      chk("t4_pc", iss_log[0][15:0], 16'h0040);
      chk("t4_ins", iss_log[0][47:32], 16'h1040);

      // redirect with stall and a full FIFO
      do_reset();
      stall = 1;
      run(12);
      redirect = 1; redirect_pc = 16'h0100;
      cycle();
      chk("t5_en", ins_en, 1'b0);
      redirect = 0; stall = 0;
      ack_log.delete(); iss_log.delete();
      run(15);
      chk("t5_addr", ack_log[0], 16'h0100);
      chk("t5_pc", iss_log[0][15:0], 16'h0100);

      // address wrap
      do_reset();
      run(5);
      redirect = 1; redirect_pc = 16'hFFFF;
      cycle();
      redirect = 0;
      ack_log.delete(); iss_log.delete();
      run(10);
      chk("t6_a0", ack_log[0], 16'hFFFF);
      chk("t6_a1", ack_log[1], 16'h0000);
      chk("t6_p0", iss_log[0][15:0], 16'hFFFF);
      chk("t6_p1", iss_log[1][15:0], 16'h0000);

      // randomized traffic
      rnd_data = 1; lat_max = 3;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         cpu_rst = ($urandom_range(0, 599) == 0);
         stall = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 39) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0)
                     ? 16'hFFFE : 16'($urandom);
         starve = ($urandom_range(0, 19) == 0);
         cycle();
      end
      cpu_rst = 0; redirect = 0; stall = 0; starve = 0;
      run(10);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
